// File: rtl/cache_lru_ctrl_pkg.sv
// Shared types for the fully associative LRU cache controller.
// The line-entry struct depends on the instance geometry, so it is declared in the top.
package cache_lru_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMP,
    WB,
    FILL,
    RESP
  } state_t;

  // Width of a way index / age value; never narrower than one bit.
  function automatic int unsigned way_bits(input int unsigned ways);
    int unsigned b;
    b = 0;
    while ((64'd1 << b) < 64'(ways)) b++;
    return (b == 0) ? 1 : b;
  endfunction

endpackage

// File: rtl/lru_age_matrix.sv
// True-LRU age registers: age 0 is most recent, age WAYS-1 is the replacement victim.
module lru_age_matrix #(
  parameter int WAYS     = 8,
  parameter int WAY_BITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                upd_en,
  input  logic [WAY_BITS-1:0] upd_way,
  output logic [WAY_BITS-1:0] oldest
);

  logic [WAY_BITS-1:0] age [WAYS];
  logic [WAY_BITS-1:0] acc_age;

  assign acc_age = age[upd_way];

  // Only ways younger than the accessed one age, so the set stays a permutation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned w = 0; w < WAYS; w++) age[w] <= WAY_BITS'(w);
    end else if (upd_en) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (WAY_BITS'(w) == upd_way)   age[w] <= '0;
        else if (age[w] < acc_age)     age[w] <= age[w] + WAY_BITS'(1);
      end
    end
  end

  always_comb begin
    oldest = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (age[w] == WAY_BITS'(WAYS - 1)) oldest = WAY_BITS'(w);
    end
  end

endmodule

// File: rtl/cache_lru_ctrl.sv
// Fully associative cache lookup/replacement controller with true LRU, per-word
// valid bitmaps, per-line dirty bits, write-back before dirty eviction and flush.
module cache_lru_ctrl
  import cache_lru_pkg::*;
#(
  parameter int ADDR_W    = 30,
  parameter int WORD_BITS = 5,
  parameter int WAYS      = 8,
  parameter int WAY_BITS  = way_bits(WAYS),
  parameter int LINE_W    = ADDR_W - WORD_BITS
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_req,
  input  logic                          i_wr,
  input  logic [ADDR_W-1:0]             i_addr,
  input  logic                          i_flush,
  output logic                          o_ready,
  output logic                          o_resp_valid,
  output logic                          o_hit,
  output logic [WAY_BITS+WORD_BITS-1:0] o_addr,
  output logic                          o_wb_req,
  output logic [LINE_W-1:0]             o_wb_line,
  output logic [WAY_BITS-1:0]           o_wb_way,
  input  logic                          i_wb_ack,
  output logic                          o_fill_req,
  output logic [LINE_W-1:0]             o_fill_line,
  output logic [WAY_BITS+WORD_BITS-1:0] o_fill_addr,
  input  logic                          i_fill_ack
);

  localparam int WORDS = 1 << WORD_BITS;

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [LINE_W-1:0] tag;
    logic [WORDS-1:0]  words;
  } line_t;

  line_t                         lines [WAYS];
  state_t                        state, state_nx;
  logic [LINE_W-1:0]             req_tag;
  logic [WORD_BITS-1:0]          req_word;
  logic                          req_wr;
  logic [WAY_BITS-1:0]           cur_way;
  logic [WAY_BITS+WORD_BITS-1:0] addr_hold;

  logic                hit, word_ok, inv_found, victim_dirty;
  logic [WAY_BITS-1:0] hit_way, inv_way, victim, oldest, resp_way;
  logic                resp, resp_hit, upd_en;

  lru_age_matrix #(
    .WAYS     (WAYS),
    .WAY_BITS (WAY_BITS)
  ) u_lru (
    .clk     (i_clk),
    .rst     (i_reset),
    .upd_en  (upd_en),
    .upd_way (resp_way),
    .oldest  (oldest)
  );

  // Tag match requires valid, so stale tags after reset/flush never hit.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!hit && lines[w].valid && lines[w].tag == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
      if (!inv_found && !lines[w].valid) begin
        inv_found = 1'b1;
        inv_way   = WAY_BITS'(w);
      end
    end
    word_ok      = lines[hit_way].words[req_word];
    victim       = inv_found ? inv_way : oldest;
    victim_dirty = lines[victim].valid && lines[victim].dirty;
  end

  always_comb begin
    state_nx = state;
    resp     = 1'b0;
    resp_hit = 1'b0;
    upd_en   = 1'b0;
    resp_way = cur_way;
    case (state)
      IDLE: if (!i_flush && i_req) state_nx = CMP;
      CMP: begin
        if (hit && word_ok) begin
          resp     = 1'b1;
          resp_hit = 1'b1;
          upd_en   = 1'b1;
          resp_way = hit_way;
          state_nx = IDLE;
        end else if (hit || !victim_dirty) begin
          state_nx = FILL;
        end else begin
          state_nx = WB;
        end
      end
      WB:   if (i_wb_ack) state_nx = FILL;
      FILL: if (i_fill_ack) state_nx = RESP;
      RESP: begin
        resp     = 1'b1;
        upd_en   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      req_tag   <= '0;
      req_word  <= '0;
      req_wr    <= 1'b0;
      cur_way   <= '0;
      addr_hold <= '0;
      for (int unsigned w = 0; w < WAYS; w++) lines[w] <= '0;
    end else begin
      state <= state_nx;
      if (resp) addr_hold <= {resp_way, req_word};
      case (state)
        IDLE: begin
          if (i_flush) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
              lines[w].valid <= 1'b0;
              lines[w].dirty <= 1'b0;
              lines[w].words <= '0;
            end
          end else if (i_req) begin
            req_tag  <= i_addr[ADDR_W-1:WORD_BITS];
            req_word <= i_addr[WORD_BITS-1:0];
            req_wr   <= i_wr;
          end
        end
        CMP: begin
          if (hit && word_ok) begin
            if (req_wr) lines[hit_way].dirty <= 1'b1;
          end else if (hit) begin
            cur_way <= hit_way;
          end else begin
            cur_way <= victim;
            if (!victim_dirty) lines[victim] <= '{1'b1, 1'b0, req_tag, '0};
          end
        end
        WB:   if (i_wb_ack) lines[cur_way] <= '{1'b1, 1'b0, req_tag, '0};
        FILL: if (i_fill_ack) lines[cur_way].words[req_word] <= 1'b1;
        RESP: if (req_wr) lines[cur_way].dirty <= 1'b1;
        default: ;
      endcase
    end
  end

  assign o_ready      = (state == IDLE) && !i_flush;
  assign o_resp_valid = resp;
  assign o_hit        = resp_hit;
  assign o_addr       = resp ? {resp_way, req_word} : addr_hold;
  assign o_wb_req     = (state == WB);
  assign o_wb_line    = lines[cur_way].tag;
  assign o_wb_way     = cur_way;
  assign o_fill_req   = (state == FILL);
  assign o_fill_line  = req_tag;
  assign o_fill_addr  = {cur_way, req_word};

endmodule

// File: tb/tb_cache_lru_ctrl.sv
// Scoreboard bench for cache_lru_ctrl: expected responses, fills and write-backs
// are queued as requests are issued and matched when the controller produces them.
module tb_cache_lru_ctrl;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_req = 1'b0, i_wr = 1'b0, i_flush = 1'b0;
  logic [29:0] i_addr = '0;
  logic        i_wb_ack = 1'b0, i_fill_ack = 1'b0;
  logic        o_ready, o_resp_valid, o_hit, o_wb_req, o_fill_req;
  logic [7:0]  o_addr, o_fill_addr;
  logic [24:0] o_wb_line, o_fill_line;
  logic [2:0]  o_wb_way;

  cache_lru_ctrl #(.ADDR_W(30), .WORD_BITS(5), .WAYS(8)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_req(i_req), .i_wr(i_wr), .i_addr(i_addr),
    .i_flush(i_flush), .o_ready(o_ready), .o_resp_valid(o_resp_valid), .o_hit(o_hit),
    .o_addr(o_addr), .o_wb_req(o_wb_req), .o_wb_line(o_wb_line), .o_wb_way(o_wb_way),
    .i_wb_ack(i_wb_ack), .o_fill_req(o_fill_req), .o_fill_line(o_fill_line),
    .o_fill_addr(o_fill_addr), .i_fill_ack(i_fill_ack)
  );

  always #5 clk = ~clk;

  typedef struct { logic hit; logic [7:0] addr; int acc_cyc; } resp_t;
  typedef struct { logic [24:0] line; logic [7:0] addr; logic after_wb; } fill_t;
  typedef struct { logic [24:0] line; logic [2:0] way; } wb_t;

  resp_t resp_q[$];
  fill_t fill_q[$];
  wb_t   wb_q[$];

  int n_checks = 0, n_pass = 0;
  int cyc = 0;
  int fill_delay = 0, wb_delay = 0, fill_cnt = 0, wb_cnt = 0;
  int wb_len = 0, wb_ack_cyc = 0;
  logic stray = 1'b0, fill_prev = 1'b0, wb_prev = 1'b0;
  resp_t me;
  fill_t mf;
  wb_t   mw;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory-side responders: ack after a programmable number of request cycles.
  initial forever begin
    @(negedge clk);
    if (o_fill_req) begin
      fill_cnt++;
      i_fill_ack = (fill_cnt > fill_delay);
    end else begin
      fill_cnt = 0;
      if (!stray) i_fill_ack = 1'b0;
    end
    if (o_wb_req) begin
      wb_cnt++;
      if (wb_cnt > wb_delay) begin
        i_wb_ack   = 1'b1;
        wb_ack_cyc = cyc;
      end
    end else begin
      wb_cnt = 0;
      if (!stray) i_wb_ack = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!i_reset) begin
      if (o_resp_valid) begin
        check_eq("resp_expected", resp_q.size() != 0, 1);
        if (resp_q.size() != 0) begin
          me = resp_q.pop_front();
          check_eq("resp_hit", o_hit, me.hit);
          check_eq("resp_addr", o_addr, me.addr);
          if (me.hit) check_eq("hit_latency", cyc, me.acc_cyc);
        end
      end
      if (o_wb_req && !wb_prev) begin
        wb_len = 0;
        check_eq("wb_expected", wb_q.size() != 0, 1);
        if (wb_q.size() != 0) begin
          mw = wb_q.pop_front();
          check_eq("wb_line", o_wb_line, mw.line);
          check_eq("wb_way", o_wb_way, mw.way);
        end
      end
      if (o_wb_req) begin
        wb_len++;
        check_eq("wb_no_fill", o_fill_req, 0);
      end
      if (o_fill_req && !fill_prev) begin
        check_eq("fill_expected", fill_q.size() != 0, 1);
        if (fill_q.size() != 0) begin
          mf = fill_q.pop_front();
          check_eq("fill_line", o_fill_line, mf.line);
          check_eq("fill_addr", o_fill_addr, mf.addr);
          if (mf.after_wb) begin
            check_eq("fill_after_wb_ack", cyc, wb_ack_cyc + 1);
            check_eq("wb_len", wb_len, wb_delay + 1);
          end
        end
      end
    end
    fill_prev = o_fill_req;
    wb_prev   = o_wb_req;
  end

  task automatic issue(input logic [29:0] addr, input logic wr, input logic hit, input logic [7:0] a);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_wait", o_ready, 1);
    i_req  = 1'b1;
    i_addr = addr;
    i_wr   = wr;
    @(posedge clk);
    #1;
    i_req = 1'b0;
    resp_q.push_back('{hit: hit, addr: a, acc_cyc: cyc});
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (resp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("resp_wait", resp_q.size(), 0);
    resp_q.delete();
  endtask

  task automatic access(input logic [29:0] addr, input logic wr, input logic hit, input logic [7:0] a);
    issue(addr, wr, hit, a);
    wait_done();
  endtask

  task automatic expect_fill(input logic [24:0] line, input logic [7:0] a, input logic after_wb);
    fill_q.push_back('{line: line, addr: a, after_wb: after_wb});
  endtask

  // Touch ways 0,7..2 (lines 8,F..A) so that way 1 becomes least recently used.
  task automatic age_out_way1();
    int order [7] = '{0, 7, 6, 5, 4, 3, 2};
    for (int k = 0; k < 7; k++)
      access(30'((order[k] + 8) << 5), 1'b0, 1'b1, 8'(order[k] << 5));
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", o_ready, 1);
    check_eq("rst_fill_req", o_fill_req, 0);
    i_reset = 1'b0;
    #1;
    check_eq("rst_resp_valid", o_resp_valid, 0);
    check_eq("rst_hit", o_hit, 0);
    check_eq("rst_addr", o_addr, 0);
    check_eq("rst_wb_req", o_wb_req, 0);
    check_eq("rst_wb_line", o_wb_line, 0);
    check_eq("rst_wb_way", o_wb_way, 0);
    check_eq("rst_fill_line", o_fill_line, 0);
    check_eq("rst_fill_addr", o_fill_addr, 0);

    // Cold miss then hit on the same word; second word of the line fills in place.
    expect_fill(25'h8, 8'h00, 1'b0);
    access(30'h100, 1'b0, 1'b0, 8'h00);
    access(30'h100, 1'b0, 1'b1, 8'h00);
    expect_fill(25'h8, 8'h01, 1'b0);
    access(30'h101, 1'b0, 1'b0, 8'h01);
    access(30'h101, 1'b0, 1'b1, 8'h01);

    // Fill remaining ways, refresh way 0, then evict the LRU way 1 (clean).
    for (int l = 9; l < 16; l++) begin
      expect_fill(25'(l), 8'((l - 8) << 5), 1'b0);
      access(30'(l << 5), 1'b0, 1'b0, 8'((l - 8) << 5));
    end
    access(30'h100, 1'b0, 1'b1, 8'h00);
    expect_fill(25'h10, 8'h20, 1'b0);
    access(30'h200, 1'b0, 1'b0, 8'h20);
    @(negedge clk);
    check_eq("addr_held", o_addr, 8'h20);

    // Bring line 9 back into way 1, write-hit it, then evict it dirty.
    age_out_way1();
    expect_fill(25'h9, 8'h20, 1'b0);
    access(30'h120, 1'b1, 1'b0, 8'h20);
    access(30'h120, 1'b1, 1'b1, 8'h20);
    age_out_way1();
    wb_delay = 5;
    wb_q.push_back('{line: 25'h9, way: 3'd1});
    expect_fill(25'h11, 8'h20, 1'b1);
    access(30'h220, 1'b0, 1'b0, 8'h20);
    wb_delay = 0;

    // Acks with no outstanding request must be ignored.
    @(negedge clk);
    stray = 1'b1;
    i_fill_ack = 1'b1;
    i_wb_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("stray_fill_req", o_fill_req, 0);
      check_eq("stray_wb_req", o_wb_req, 0);
      check_eq("stray_ready", o_ready, 1);
    end
    stray = 1'b0;
    i_fill_ack = 1'b0;
    i_wb_ack = 1'b0;
    access(30'h100, 1'b0, 1'b1, 8'h00);

    // Flush beats a same-cycle request; line 8 then misses into way 0.
    @(negedge clk);
    i_flush = 1'b1;
    i_req = 1'b1;
    i_addr = 30'h100;
    #1;
    check_eq("flush_ready_low", o_ready, 0);
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    i_req = 1'b0;
    @(negedge clk);
    check_eq("flush_not_accepted", o_ready, 1);
    check_eq("flush_no_fill", o_fill_req, 0);
    expect_fill(25'h8, 8'h00, 1'b0);
    access(30'h100, 1'b0, 1'b0, 8'h00);

    // Asynchronous reset while a fill is outstanding.
    fill_delay = 20;
    expect_fill(25'h18, 8'h20, 1'b0);
    issue(30'h300, 1'b0, 1'b0, 8'h20);
    n = 0;
    while (!o_fill_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("fill_wait", o_fill_req, 1);
    @(posedge clk);
    #2;
    i_reset = 1'b1;
    #1;
    check_eq("async_rst_fill_req", o_fill_req, 0);
    check_eq("async_rst_ready", o_ready, 1);
    resp_q.delete();
    @(negedge clk);
    i_reset = 1'b0;
    fill_delay = 0;
    expect_fill(25'h8, 8'h00, 1'b0);
    access(30'h100, 1'b0, 1'b0, 8'h00);

    repeat (3) @(negedge clk);
    check_eq("fill_q_empty", fill_q.size(), 0);
    check_eq("wb_q_empty", wb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
